// File: rtl/spwm_pkg.sv
// Shared definitions for the SPWM drive: sequencer state encodings and default datapath widths.
`timescale 1ns/1ps

package spwm_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int AMP_W_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRECHG = 3'd1,
    ST_RAMP   = 3'd2,
    ST_RUN    = 3'd3,
    ST_STOP   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

endpackage

// File: rtl/spwm_ramp_step.sv
// Saturating single-step mover: on a step request the value moves by one toward its target and never
// passes it. at_target_o reflects the value that will be stored, so the caller can leave a ramp on the
// same edge that lands the final step.
`timescale 1ns/1ps

module spwm_ramp_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] cur_i,
  input  logic [W-1:0] target_i,
  input  logic         step_i,
  output logic [W-1:0] next_o,
  output logic         at_target_o
);

  // Move one count toward the target only when a step is requested; otherwise hold the value
  always_comb begin
    next_o = cur_i;
    if (step_i) begin
      if (cur_i < target_i) begin
        next_o = cur_i + W'(1);
      end else if (cur_i > target_i) begin
        next_o = cur_i - W'(1);
      end
    end
  end

  assign at_target_o = (next_o == target_i);

endmodule

// File: rtl/spwm_run_sequencer.sv
// Start/stop/fault sequencer for the single-phase SPWM drive. Shadows the host configuration on start,
// precharges the bootstrap caps, soft-starts and soft-stops divider and amplitude, and drops the bridge
// on fault. Optional host watchdog is built in when SPWM_WDT_EN is defined.
`timescale 1ns/1ps

module spwm_run_sequencer
  import spwm_pkg::*;
#(
  parameter int DIV_W      = DIV_W_DEF,
  parameter int AMP_W      = AMP_W_DEF,
  parameter int PRECHG_CYC = 5000,
  parameter int WDT_CYC    = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             fault_in,
  input  logic             fault_clr,
  input  logic             kick,
  input  logic [DIV_W-1:0] cfg_div_start,
  input  logic [DIV_W-1:0] cfg_div_target,
  input  logic [15:0]      cfg_ramp_tick,
  input  logic [AMP_W-1:0] cfg_amp_target,
  input  logic             cfg_mode,
  input  logic [4:0]       cfg_deadtime,
  output logic [DIV_W-1:0] freq_mod_div,
  output logic [AMP_W-1:0] amp,
  output logic             mode,
  output logic [4:0]       deadtime,
  output logic             dp_rst_n,
  output logic             precharge,
  output logic             gate_en,
  output logic [2:0]       state,
  output logic             fault_latched
);

  localparam int PC_W = (PRECHG_CYC > 1) ? $clog2(PRECHG_CYC) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRECHG_CYC - 1);

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [AMP_W-1:0] amp_q;
  logic             mode_q;
  logic [4:0]       deadtime_q;
  logic             dpRstN_q;
  logic             precharge_q;
  logic             gateEn_q;
  logic             faultLatched_q;

  logic [DIV_W-1:0] divStart_q;
  logic [DIV_W-1:0] divTarget_q;
  logic [AMP_W-1:0] ampTarget_q;
  logic [15:0]      tick_q;

  logic [PC_W-1:0]  prechgCnt_q;
  logic [15:0]      tickCnt_q;

  logic [15:0]      tickEff;
  logic             tickHit;
  logic             stepEn;
  logic [DIV_W-1:0] divGoal;
  logic [AMP_W-1:0] ampGoal;
  logic [DIV_W-1:0] divNext_d;
  logic [AMP_W-1:0] ampNext_d;
  logic             divAt;
  logic             ampAt;
  logic             wdtExpired;

  assign tickEff = (tick_q == 16'd0) ? 16'd1 : tick_q;
  assign tickHit = (tickCnt_q == (tickEff - 16'd1));
  assign stepEn  = tickHit && ((state_q == ST_RAMP) || (state_q == ST_STOP));
  assign divGoal = (state_q == ST_STOP) ? divStart_q : divTarget_q;
  assign ampGoal = (state_q == ST_STOP) ? {AMP_W{1'b0}} : ampTarget_q;

  spwm_ramp_step #(.W(DIV_W)) u_div_step (
    .cur_i       (div_q),
    .target_i    (divGoal),
    .step_i      (stepEn),
    .next_o      (divNext_d),
    .at_target_o (divAt)
  );

  spwm_ramp_step #(.W(AMP_W)) u_amp_step (
    .cur_i       (amp_q),
    .target_i    (ampGoal),
    .step_i      (stepEn),
    .next_o      (ampNext_d),
    .at_target_o (ampAt)
  );

`ifdef SPWM_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYC + 1);
  localparam logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(WDT_CYC);
  logic [WDT_W-1:0] wdtCnt_q;

  // Count cycles since the last host kick, held clear during precharge so every ramp starts fresh
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdtCnt_q <= '0;
    end else if (kick || (state_q == ST_PRECHG)) begin
      wdtCnt_q <= '0;
    end else if (wdtCnt_q != WDT_LIMIT) begin
      wdtCnt_q <= wdtCnt_q + WDT_W'(1);
    end
  end

  assign wdtExpired = (wdtCnt_q == WDT_LIMIT);
`else
  localparam int unused_wdt_cyc = WDT_CYC;
  logic unused_kick;
  assign unused_kick = kick;
  assign wdtExpired  = 1'b0;
`endif

  // Sequencer: fault overrides everything, otherwise walk IDLE->PRECHG->RAMP->RUN->STOP with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      div_q          <= '0;
      amp_q          <= '0;
      mode_q         <= 1'b0;
      deadtime_q     <= '0;
      dpRstN_q       <= 1'b0;
      precharge_q    <= 1'b0;
      gateEn_q       <= 1'b0;
      faultLatched_q <= 1'b0;
      divStart_q     <= '0;
      divTarget_q    <= '0;
      ampTarget_q    <= '0;
      tick_q         <= '0;
      prechgCnt_q    <= '0;
      tickCnt_q      <= '0;
    end else if (fault_in) begin
      state_q        <= ST_FAULT;
      amp_q          <= '0;
      dpRstN_q       <= 1'b0;
      precharge_q    <= 1'b0;
      gateEn_q       <= 1'b0;
      faultLatched_q <= 1'b1;
      prechgCnt_q    <= '0;
      tickCnt_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            divStart_q  <= cfg_div_start;
            divTarget_q <= cfg_div_target;
            ampTarget_q <= cfg_amp_target;
            tick_q      <= cfg_ramp_tick;
            mode_q      <= cfg_mode;
            deadtime_q  <= cfg_deadtime;
            div_q       <= cfg_div_start;
            amp_q       <= '0;
            precharge_q <= 1'b1;
            dpRstN_q    <= 1'b0;
            gateEn_q    <= 1'b0;
            prechgCnt_q <= '0;
            tickCnt_q   <= '0;
            state_q     <= ST_PRECHG;
          end
        end
        ST_PRECHG: begin
          if (stop) begin
            precharge_q <= 1'b0;
            tickCnt_q   <= '0;
            state_q     <= ST_IDLE;
          end else if (prechgCnt_q == PC_LAST) begin
            precharge_q <= 1'b0;
            dpRstN_q    <= 1'b1;
            gateEn_q    <= 1'b1;
            tickCnt_q   <= '0;
            state_q     <= ST_RAMP;
          end else begin
            prechgCnt_q <= prechgCnt_q + PC_W'(1);
          end
        end
        ST_RAMP: begin
          if (stop || wdtExpired) begin
            tickCnt_q <= '0;
            state_q   <= ST_STOP;
          end else begin
            div_q <= divNext_d;
            amp_q <= ampNext_d;
            if (divAt && ampAt) begin
              tickCnt_q <= '0;
              state_q   <= ST_RUN;
            end else begin
              tickCnt_q <= tickHit ? 16'd0 : (tickCnt_q + 16'd1);
            end
          end
        end
        ST_RUN: begin
          if (stop || wdtExpired) begin
            tickCnt_q <= '0;
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          div_q <= divNext_d;
          amp_q <= ampNext_d;
          if (divAt && ampAt) begin
            gateEn_q  <= 1'b0;
            dpRstN_q  <= 1'b0;
            tickCnt_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            tickCnt_q <= tickHit ? 16'd0 : (tickCnt_q + 16'd1);
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            faultLatched_q <= 1'b0;
            tickCnt_q      <= '0;
            state_q        <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign freq_mod_div  = div_q;
  assign amp           = amp_q;
  assign mode          = mode_q;
  assign deadtime      = deadtime_q;
  assign dp_rst_n      = dpRstN_q;
  assign precharge     = precharge_q;
  assign gate_en       = gateEn_q;
  assign state         = state_q;
  assign fault_latched = faultLatched_q;

endmodule

// File: tb/tb_spwm_run_sequencer.sv
// Testbench for spwm_run_sequencer: table of per-cycle stimulus with expected outputs queued on a
// scoreboard and compared one cycle later, plus hand-written zero-length ramp, async reset and
// (when SPWM_WDT_EN is defined) watchdog sequences.
`timescale 1ns/1ps

module tb_spwm_run_sequencer;

  localparam int DIV_W      = 16;
  localparam int AMP_W      = 10;
  localparam int PRECHG_CYC = 8;
  localparam int WDT_CYC    = 20;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRECHG = 3'd1;
  localparam logic [2:0] S_RAMP   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  typedef struct packed {
    logic [2:0]       st;
    logic [DIV_W-1:0] div;
    logic [AMP_W-1:0] amp;
    logic             gate;
    logic             dp;
    logic             pc;
    logic             flt;
    logic             md;
    logic [4:0]       dt;
  } outs_t;

  typedef struct {
    logic  start;
    logic  stop;
    logic  fin;
    logic  fclr;
    logic  cfgAlt;
    outs_t exp;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic             fault_in;
  logic             fault_clr;
  logic             kick;
  logic [DIV_W-1:0] cfg_div_start;
  logic [DIV_W-1:0] cfg_div_target;
  logic [15:0]      cfg_ramp_tick;
  logic [AMP_W-1:0] cfg_amp_target;
  logic             cfg_mode;
  logic [4:0]       cfg_deadtime;
  logic [DIV_W-1:0] freq_mod_div;
  logic [AMP_W-1:0] amp;
  logic             mode;
  logic [4:0]       deadtime;
  logic             dp_rst_n;
  logic             precharge;
  logic             gate_en;
  logic [2:0]       state;
  logic             fault_latched;

  int    checks   = 0;
  int    failures = 0;
  outs_t sbQ[$];
  string sbName[$];
  outs_t monExp;
  string monName;
  vec_t  vecs[$];
  logic  autoKick = 1'b1;
  int    kickCnt  = 0;
  int    waitCnt;

  spwm_run_sequencer #(
    .DIV_W      (DIV_W),
    .AMP_W      (AMP_W),
    .PRECHG_CYC (PRECHG_CYC),
    .WDT_CYC    (WDT_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .fault_in       (fault_in),
    .fault_clr      (fault_clr),
    .kick           (kick),
    .cfg_div_start  (cfg_div_start),
    .cfg_div_target (cfg_div_target),
    .cfg_ramp_tick  (cfg_ramp_tick),
    .cfg_amp_target (cfg_amp_target),
    .cfg_mode       (cfg_mode),
    .cfg_deadtime   (cfg_deadtime),
    .freq_mod_div   (freq_mod_div),
    .amp            (amp),
    .mode           (mode),
    .deadtime       (deadtime),
    .dp_rst_n       (dp_rst_n),
    .precharge      (precharge),
    .gate_en        (gate_en),
    .state          (state),
    .fault_latched  (fault_latched)
  );

  // 50 MHz system clock
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Host kicks every ten cycles while autoKick is set
  initial begin
    kick = 1'b0;
    forever begin
      @(negedge clk);
      kickCnt++;
      kick = autoKick && ((kickCnt % 10) == 0);
    end
  end

  // Hard time limit so the run always ends with a summary
  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL timeout: got simulation still running, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic outs_t mkOut(input logic [2:0] st, input int dv, input int am,
                                  input logic g, input logic d, input logic p,
                                  input logic f, input logic m, input logic [4:0] t);
    outs_t o;
    o.st   = st;
    o.div  = DIV_W'(dv);
    o.amp  = AMP_W'(am);
    o.gate = g;
    o.dp   = d;
    o.pc   = p;
    o.flt  = f;
    o.md   = m;
    o.dt   = t;
    return o;
  endfunction

  function automatic outs_t getOut();
    outs_t o;
    o = {state, freq_mod_div, amp, gate_en, dp_rst_n, precharge, fault_latched, mode, deadtime};
    return o;
  endfunction

  task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got st=%0d div=%0d amp=%0d gate=%0b dp=%0b pc=%0b flt=%0b mode=%0b dt=%0d, expected st=%0d div=%0d amp=%0d gate=%0b dp=%0b pc=%0b flt=%0b mode=%0b dt=%0d",
               name, act.st, act.div, act.amp, act.gate, act.dp, act.pc, act.flt, act.md, act.dt,
               exp.st, exp.div, exp.amp, exp.gate, exp.dp, exp.pc, exp.flt, exp.md, exp.dt);
    end
  endtask

  task automatic checkState(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got state=%0d, expected state=%0d", name, act, exp);
    end
  endtask

  task automatic setCfg(input logic alt);
    if (alt) begin
      cfg_div_start  = 16'd10;
      cfg_div_target = 16'd20;
      cfg_amp_target = 10'd500;
      cfg_ramp_tick  = 16'd7;
      cfg_mode       = 1'b0;
      cfg_deadtime   = 5'd3;
    end else begin
      cfg_div_start  = 16'd100;
      cfg_div_target = 16'd96;
      cfg_amp_target = 10'd3;
      cfg_ramp_tick  = 16'd2;
      cfg_mode       = 1'b1;
      cfg_deadtime   = 5'd7;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic f, input logic c,
                               input outs_t e, input string name);
    @(negedge clk);
    start     = s;
    stop      = p;
    fault_in  = f;
    fault_clr = c;
    sbQ.push_back(e);
    sbName.push_back(name);
    @(posedge clk);
    #2;
    start     = 1'b0;
    stop      = 1'b0;
    fault_clr = 1'b0;
  endtask

  task automatic addVec(input logic s, input logic p, input logic f, input logic c,
                        input logic a, input outs_t e);
    vec_t v;
    v.start  = s;
    v.stop   = p;
    v.fin    = f;
    v.fclr   = c;
    v.cfgAlt = a;
    v.exp    = e;
    vecs.push_back(v);
  endtask

  // Scoreboard: compare the oldest expected record just after each active edge
  always @(posedge clk) begin
    #1;
    if (sbQ.size() > 0) begin
      monExp  = sbQ.pop_front();
      monName = sbName.pop_front();
      checkOutput(monName, getOut(), monExp);
    end
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    fault_in  = 1'b0;
    fault_clr = 1'b0;
    setCfg(1'b0);

    addVec(1, 0, 0, 0, 0, mkOut(S_PRECHG, 100, 0, 0, 0, 1, 0, 1, 7));
    for (int i = 1; i < PRECHG_CYC; i++)
      addVec(0, 0, 0, 0, 0, mkOut(S_PRECHG, 100, 0, 0, 0, 1, 0, 1, 7));
    for (int k = 0; k <= 8; k++)
      addVec(0, 0, 0, 0, 0, mkOut((k < 8) ? S_RAMP : S_RUN, 100 - k / 2,
                                  (k / 2 > 3) ? 3 : k / 2, 1, 1, 0, 0, 1, 7));
    for (int i = 0; i < 5; i++)
      addVec(0, 0, 0, 0, (i >= 2), mkOut(S_RUN, 96, 3, 1, 1, 0, 0, 1, 7));
    addVec(0, 1, 0, 0, 0, mkOut(S_STOP, 96, 3, 1, 1, 0, 0, 1, 7));
    for (int k = 1; k <= 8; k++) begin
      if (k < 8)
        addVec((k == 3), 0, 0, 0, 0, mkOut(S_STOP, 96 + k / 2, 3 - k / 2, 1, 1, 0, 0, 1, 7));
      else
        addVec(0, 0, 0, 0, 0, mkOut(S_IDLE, 100, 0, 0, 0, 0, 0, 1, 7));
    end
    addVec(1, 1, 0, 0, 1, mkOut(S_IDLE, 100, 0, 0, 0, 0, 0, 1, 7));
    addVec(0, 0, 0, 0, 0, mkOut(S_IDLE, 100, 0, 0, 0, 0, 0, 1, 7));
    addVec(1, 0, 0, 0, 0, mkOut(S_PRECHG, 100, 0, 0, 0, 1, 0, 1, 7));
    for (int i = 1; i < PRECHG_CYC; i++)
      addVec(0, 0, 0, 0, 0, mkOut(S_PRECHG, 100, 0, 0, 0, 1, 0, 1, 7));
    for (int k = 0; k <= 4; k++)
      addVec(0, 0, 0, 0, 0, mkOut(S_RAMP, 100 - k / 2, k / 2, 1, 1, 0, 0, 1, 7));
    addVec(0, 0, 1, 0, 0, mkOut(S_FAULT, 98, 0, 0, 0, 0, 1, 1, 7));
    addVec(0, 0, 1, 1, 0, mkOut(S_FAULT, 98, 0, 0, 0, 0, 1, 1, 7));
    addVec(0, 0, 0, 0, 0, mkOut(S_FAULT, 98, 0, 0, 0, 0, 1, 1, 7));
    addVec(0, 0, 0, 1, 0, mkOut(S_IDLE, 98, 0, 0, 0, 0, 0, 1, 7));

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", getOut(), '0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] table: ramp, run, stop, start+stop, fault (%0d vectors)", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      setCfg(vecs[i].cfgAlt);
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].fin, vecs[i].fclr,
                    vecs[i].exp, $sformatf("vec%0d", i));
    end

    $display("[TB] zero-length ramp with tick=0");
    cfg_div_start  = 16'd50;
    cfg_div_target = 16'd50;
    cfg_amp_target = 10'd0;
    cfg_ramp_tick  = 16'd0;
    cfg_mode       = 1'b0;
    cfg_deadtime   = 5'd2;
    applyStimulus(1, 0, 0, 0, mkOut(S_PRECHG, 50, 0, 0, 0, 1, 0, 0, 2), "zr_prechg0");
    for (int i = 1; i < PRECHG_CYC; i++)
      applyStimulus(0, 0, 0, 0, mkOut(S_PRECHG, 50, 0, 0, 0, 1, 0, 0, 2), $sformatf("zr_prechg%0d", i));
    applyStimulus(0, 0, 0, 0, mkOut(S_RAMP, 50, 0, 1, 1, 0, 0, 0, 2), "zr_ramp");
    applyStimulus(0, 0, 0, 0, mkOut(S_RUN, 50, 0, 1, 1, 0, 0, 0, 2), "zr_run");
    applyStimulus(0, 1, 0, 0, mkOut(S_STOP, 50, 0, 1, 1, 0, 0, 0, 2), "zr_stop");
    applyStimulus(0, 0, 0, 0, mkOut(S_IDLE, 50, 0, 0, 0, 0, 0, 0, 2), "zr_idle");

    $display("[TB] asynchronous reset mid-ramp");
    setCfg(1'b0);
    applyStimulus(1, 0, 0, 0, mkOut(S_PRECHG, 100, 0, 0, 0, 1, 0, 1, 7), "ar_prechg0");
    for (int i = 1; i < PRECHG_CYC; i++)
      applyStimulus(0, 0, 0, 0, mkOut(S_PRECHG, 100, 0, 0, 0, 1, 0, 1, 7), $sformatf("ar_prechg%0d", i));
    for (int k = 0; k <= 2; k++)
      applyStimulus(0, 0, 0, 0, mkOut(S_RAMP, 100 - k / 2, k / 2, 1, 1, 0, 0, 1, 7), $sformatf("ar_ramp%0d", k));
    #5;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", getOut(), '0);
    @(negedge clk);
    rst = 1'b0;

`ifdef SPWM_WDT_EN
    $display("[TB] watchdog: no kicks in RUN");
    autoKick = 1'b0;
    applyStimulus(1, 0, 0, 0, mkOut(S_PRECHG, 100, 0, 0, 0, 1, 0, 1, 7), "wdt_start");
    waitCnt = 0;
    while ((state !== S_STOP) && (waitCnt < 100)) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    checkState("wdt_trip", state, S_STOP);
    waitCnt = 0;
    while ((state !== S_IDLE) && (waitCnt < 100)) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    checkState("wdt_back_idle", state, S_IDLE);
    $display("[TB] watchdog: kicks every 10 cycles");
    autoKick = 1'b1;
    applyStimulus(1, 0, 0, 0, mkOut(S_PRECHG, 100, 0, 0, 0, 1, 0, 1, 7), "wdt_kick_start");
    repeat (60) @(posedge clk);
    #1;
    checkState("wdt_kept_run", state, S_RUN);
`endif

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
